// File: rtl/exec_run_controller.sv
// rtl/exec_run_controller.sv - program-execution supervisor gating CPU T-state stepping
//
// Purpose: sequences a datapath clear after reset or restart, then gates the
// Control unit's T-state advance (run_en) for free-run, stop at instruction
// boundary, single-step and halt. Provides a run LED and debug counters.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start_p     in   pulse: start / resume / restart after halt
//   stop_p      in   pulse: stop at next instruction boundary
//   step_p      in   pulse: run exactly one instruction while paused
//   step_mode   in   level: single-step operation
//   halt        in   Control: halt decoded (only meaningful while run_en=1)
//   instr_done  in   Control: last T-state of instruction (only while run_en=1)
//   clr         out  datapath/control synchronous clear
//   run_en      out  Control T-state advance enable
//   run_led     out  running indicator
//   state       out  encoded FSM state for debug
//   cyc_cnt     out  saturating count of enabled cycles
//   instr_cnt   out  saturating count of completed instructions

module exec_run_controller #(
  parameter int CLR_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start_p,
  input  logic             stop_p,
  input  logic             step_p,
  input  logic             step_mode,
  input  logic             halt,
  input  logic             instr_done,
  output logic             clr,
  output logic             run_en,
  output logic             run_led,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_PAUSE  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam int TW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [TW-1:0]    CLR_LOAD = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          cur, nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic            stop_req, stop_req_nxt;
  logic            cnt_clear;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= S_CLEAR;
      tmr       <= CLR_LOAD;
      stop_req  <= 1'b0;
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      cur      <= nxt;
      tmr      <= tmr_nxt;
      stop_req <= stop_req_nxt;
      if (cnt_clear) begin
        cyc_cnt   <= '0;
        instr_cnt <= '0;
      end else if (run_en) begin
        if (cyc_cnt != CNT_MAX)
          cyc_cnt <= cyc_cnt + CNT_ONE;
        // Completion still counts in the cycle where halt is also raised.
        if (instr_done && (instr_cnt != CNT_MAX))
          instr_cnt <= instr_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    nxt          = cur;
    tmr_nxt      = tmr;
    stop_req_nxt = 1'b0;
    cnt_clear    = 1'b0;
    case (cur)
      S_CLEAR: begin
        cnt_clear = 1'b1;
        if (tmr == '0)
          nxt = S_IDLE;
        else
          tmr_nxt = tmr - TMR_ONE;
      end
      S_IDLE: begin
        // A simultaneous stop cancels the start.
        if (start_p && !stop_p)
          nxt = step_mode ? S_PAUSE : S_RUN;
      end
      S_RUN: begin
        // Stop requests are deferred until the current instruction finishes;
        // step_mode asserted while running acts as a pending stop.
        if (halt)
          nxt = S_HALTED;
        else if (instr_done && (stop_req || stop_p || step_mode))
          nxt = S_PAUSE;
        else
          stop_req_nxt = stop_req | stop_p | step_mode;
      end
      S_PAUSE: begin
        if (step_p)
          nxt = S_STEP;
        else if (start_p && !step_mode)
          nxt = S_RUN;
      end
      S_STEP: begin
        if (halt)
          nxt = S_HALTED;
        else if (instr_done)
          nxt = S_PAUSE;
      end
      S_HALTED: begin
        if (start_p) begin
          nxt       = S_CLEAR;
          tmr_nxt   = CLR_LOAD;
          cnt_clear = 1'b1;
        end
      end
      default: begin
        nxt       = S_CLEAR;
        tmr_nxt   = CLR_LOAD;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Moore decode of the registered state; reset forces CLEAR so run_en
  // drops asynchronously.
  always_comb begin
    clr     = (cur == S_CLEAR);
    run_en  = (cur == S_RUN) || (cur == S_STEP);
    run_led = (cur == S_RUN) || (cur == S_STEP) || (cur == S_PAUSE);
    state   = cur;
  end

endmodule

// File: tb/tb_exec_run_controller.sv
// tb/tb_exec_run_controller.sv - scoreboard bench for exec_run_controller

module tb_exec_run_controller;

  logic        clk;
  logic        reset_n;
  logic        start_p, stop_p, step_p, step_mode, halt, instr_done;
  logic        clr, run_en, run_led;
  logic [2:0]  state;
  logic [31:0] cyc_cnt, instr_cnt;
  logic        clr4, run_en4, run_led4;
  logic [2:0]  state4;
  logic [3:0]  cyc_cnt4, instr_cnt4;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  localparam int S_STATE = 0, S_CLR = 1, S_RUNEN = 2, S_LED = 3, S_CYC = 4,
                 S_INS = 5, S_CYC4 = 6, S_INS4 = 7, S_EDGES = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  exec_run_controller #(.CLR_CYCLES(4), .CNT_W(32)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .start_p(start_p), .stop_p(stop_p),
    .step_p(step_p), .step_mode(step_mode), .halt(halt), .instr_done(instr_done),
    .clr(clr), .run_en(run_en), .run_led(run_led), .state(state),
    .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
  );

  exec_run_controller #(.CLR_CYCLES(4), .CNT_W(4)) dut4 (
    .CLOCK_50(clk), .reset_n(reset_n), .start_p(start_p), .stop_p(stop_p),
    .step_p(step_p), .step_mode(step_mode), .halt(halt), .instr_done(instr_done),
    .clr(clr4), .run_en(run_en4), .run_led(run_led4), .state(state4),
    .cyc_cnt(cyc_cnt4), .instr_cnt(instr_cnt4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_STATE: return {29'd0, state};
      S_CLR:   return {31'd0, clr};
      S_RUNEN: return {31'd0, run_en};
      S_LED:   return {31'd0, run_led};
      S_CYC:   return cyc_cnt;
      S_INS:   return instr_cnt;
      S_CYC4:  return {28'd0, cyc_cnt4};
      S_INS4:  return {28'd0, instr_cnt4};
      default: return edge_n;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges spent with clr high; bounded so a stuck CLEAR still ends.
  task automatic count_clear();
    edge_n = 0;
    while (clr && edge_n < 10) begin
      tick(1);
      edge_n++;
    end
  endtask

  initial begin
    reset_n = 1'b0; start_p = 1'b0; stop_p = 1'b0; step_p = 1'b0;
    step_mode = 1'b0; halt = 1'b0; instr_done = 1'b0;

    // Reset and clear sequence
    tick(2);
    expect_out("rst_state", S_STATE, 0);
    expect_out("rst_clr", S_CLR, 1);
    expect_out("rst_run_en", S_RUNEN, 0);
    expect_out("rst_led", S_LED, 0);
    expect_out("rst_cyc", S_CYC, 0);
    drain();
    reset_n = 1'b1;
    count_clear();
    expect_out("clr_edges", S_EDGES, 4);
    expect_out("idle_state", S_STATE, 1);
    expect_out("idle_run_en", S_RUNEN, 0);
    expect_out("idle_led", S_LED, 0);
    expect_out("idle_cyc", S_CYC, 0);
    expect_out("idle_ins", S_INS, 0);
    drain();

    // Free run: 20 cycles, instruction every 5
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    expect_out("run_state", S_STATE, 2);
    expect_out("run_en_first", S_RUNEN, 1);
    expect_out("run_led", S_LED, 1);
    drain();
    for (int i = 0; i < 20; i++) begin
      instr_done = (i % 5 == 4);
      tick(1);
    end
    instr_done = 1'b0;
    expect_out("run_cyc20", S_CYC, 20);
    expect_out("run_ins4", S_INS, 4);
    expect_out("run_still", S_STATE, 2);
    expect_out("sat_cyc4", S_CYC4, 15);
    expect_out("sat_ins4", S_INS4, 4);
    drain();

    // Stop at T2 of a 5-cycle instruction completes the instruction first
    for (int i = 0; i < 5; i++) begin
      stop_p     = (i == 1);
      instr_done = (i == 4);
      expect_out("stop_run_en_hold", S_RUNEN, 1);
      drain();
      tick(1);
    end
    stop_p = 1'b0; instr_done = 1'b0;
    expect_out("stop_pause", S_STATE, 4);
    expect_out("stop_run_en", S_RUNEN, 0);
    expect_out("stop_led", S_LED, 1);
    expect_out("stop_cyc", S_CYC, 25);
    expect_out("stop_ins", S_INS, 5);
    drain();

    // Resume; pending stop must not linger
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    expect_out("resume_state", S_STATE, 2);
    drain();
    for (int i = 0; i < 5; i++) begin
      instr_done = (i == 4);
      tick(1);
    end
    instr_done = 1'b0;
    expect_out("resume_no_stop", S_STATE, 2);
    expect_out("resume_ins", S_INS, 6);
    drain();

    // step_mode while running pauses at the next boundary
    step_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_done = (i == 4);
      tick(1);
    end
    instr_done = 1'b0;
    expect_out("sm_pause", S_STATE, 4);
    expect_out("sm_cyc", S_CYC, 35);
    expect_out("sm_ins", S_INS, 7);
    drain();

    // PAUSE: start_p ignored in step mode
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    expect_out("pause_start_ign", S_STATE, 4);
    drain();

    // Three single steps of 4-cycle instructions
    for (int k = 0; k < 3; k++) begin
      step_p  = 1'b1;
      start_p = (k == 2);
      tick(1);
      step_p = 1'b0; start_p = 1'b0;
      expect_out("step_state", S_STATE, 3);
      expect_out("step_run_en", S_RUNEN, 1);
      drain();
      for (int i = 0; i < 4; i++) begin
        instr_done = (i == 3);
        stop_p     = (k == 0 && i == 1);
        tick(1);
      end
      instr_done = 1'b0; stop_p = 1'b0;
      expect_out("step_back_pause", S_STATE, 4);
      drain();
    end
    expect_out("step_cyc", S_CYC, 47);
    expect_out("step_ins", S_INS, 10);
    drain();

    // Halt with instr_done in same cycle
    step_mode = 1'b0;
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    tick(2);
    halt = 1'b1; instr_done = 1'b1;
    tick(1);
    halt = 1'b0; instr_done = 1'b0;
    expect_out("halt_state", S_STATE, 5);
    expect_out("halt_run_en", S_RUNEN, 0);
    expect_out("halt_led", S_LED, 0);
    expect_out("halt_cyc", S_CYC, 50);
    expect_out("halt_ins", S_INS, 11);
    expect_out("halt_ins4", S_INS4, 11);
    expect_out("halt_cyc4", S_CYC4, 15);
    drain();
    instr_done = 1'b1; step_p = 1'b1;
    tick(2);
    instr_done = 1'b0; step_p = 1'b0;
    expect_out("halt_ignore_state", S_STATE, 5);
    expect_out("halt_ignore_ins", S_INS, 11);
    drain();

    // Restart from halt
    start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    expect_out("restart_state", S_STATE, 0);
    expect_out("restart_clr", S_CLR, 1);
    expect_out("restart_cyc", S_CYC, 0);
    expect_out("restart_ins", S_INS, 0);
    drain();
    count_clear();
    expect_out("restart_edges", S_EDGES, 4);
    expect_out("restart_idle", S_STATE, 1);
    drain();

    // start_p with stop_p in IDLE: stop wins
    start_p = 1'b1; stop_p = 1'b1;
    tick(1);
    start_p = 1'b0; stop_p = 1'b0;
    expect_out("idle_stop_wins", S_STATE, 1);
    drain();

    // Reset asserted mid-STEP
    step_mode = 1'b1; start_p = 1'b1;
    tick(1);
    start_p = 1'b0;
    expect_out("sm_start_pause", S_STATE, 4);
    drain();
    step_p = 1'b1;
    tick(1);
    step_p = 1'b0;
    tick(2);
    expect_out("midstep_state", S_STATE, 3);
    expect_out("midstep_cyc", S_CYC, 2);
    drain();
    #5;
    reset_n = 1'b0;
    #1;
    expect_out("async_state", S_STATE, 0);
    expect_out("async_run_en", S_RUNEN, 0);
    expect_out("async_clr", S_CLR, 1);
    expect_out("async_cyc", S_CYC, 0);
    expect_out("async_ins", S_INS, 0);
    drain();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    count_clear();
    expect_out("rerst_edges", S_EDGES, 4);
    expect_out("rerst_idle", S_STATE, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
